// File: rtl/pc_gen.sv
//==============================================================================
// Module   : pc_gen
// Purpose  : Fetch program-counter generator with prioritized redirects,
//            stall-deferred branch hold and fetch address-error detection.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module pc_gen #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_4180),
    parameter int unsigned      STEP       = 4,
    parameter logic [WIDTH-1:0] IMEM_LO    = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] IMEM_HI    = WIDTH'(32'h0000_6FFC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc_f,
    output logic [WIDTH-1:0] pc_seq,
    output logic             fetch_adel,
    output logic             redir_pending
);

    localparam logic [WIDTH-1:0] c_STEP = WIDTH'(STEP);

    // Declaration initializer gives RESET_PC before the first reset edge.
    logic [WIDTH-1:0] pc_q = RESET_PC;
    logic [WIDTH-1:0] pc_d;
    logic             pend_q = 1'b0;
    logic             pend_d;
    logic [WIDTH-1:0] tgt_q = '0;
    logic [WIDTH-1:0] tgt_d;

    logic             w_misaligned;
    logic             w_out_of_range;

    assign pc_seq = pc_q + c_STEP;

    always_comb begin
        pc_d   = pc_q;
        pend_d = pend_q;
        tgt_d  = tgt_q;
        if (exc_req) begin
            pc_d   = EXC_VECTOR;
            pend_d = 1'b0;
        end else if (eret_req) begin
            pc_d   = epc;
            pend_d = 1'b0;
        end else if (stall) begin
            // Latest branch seen during a stall wins.
            if (br_valid) begin
                tgt_d  = br_target;
                pend_d = 1'b1;
            end
        end else if (br_valid) begin
            pc_d   = br_target;
            pend_d = 1'b0;
        end else if (pend_q) begin
            pc_d   = tgt_q;
            pend_d = 1'b0;
        end else begin
            pc_d   = pc_seq;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            pend_q <= 1'b0;
            tgt_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            pend_q <= pend_d;
            tgt_q  <= tgt_d;
        end
    end

    assign w_misaligned   = (pc_q[1:0] != 2'b00);
    assign w_out_of_range = (pc_q < IMEM_LO) || (pc_q > IMEM_HI);

    assign pc_f          = pc_q;
    assign fetch_adel    = w_misaligned || w_out_of_range;
    assign redir_pending = pend_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
//==============================================================================
// Module   : tb_pc_gen
// Purpose  : Directed self-checking bench for pc_gen against a behavioural model.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic        exc_req = 1'b0;
    logic        eret_req = 1'b0;
    logic [31:0] epc = '0;

    logic [31:0] pc_f, pc_seq;
    logic        fetch_adel, redir_pending;
    logic [31:0] pc_f2, pc_seq2;
    logic        fetch_adel2, redir_pending2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
        .br_target(br_target), .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
        .pc_f(pc_f), .pc_seq(pc_seq), .fetch_adel(fetch_adel),
        .redir_pending(redir_pending)
    );

    pc_gen #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
        .br_target(br_target), .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
        .pc_f(pc_f2), .pc_seq(pc_seq2), .fetch_adel(fetch_adel2),
        .redir_pending(redir_pending2)
    );

    // Behavioural model: where does the next fetch come from, given the rules.
    logic [31:0] m_pc   = 32'h0000_3000;
    logic        m_pend = 1'b0;
    logic [31:0] m_hold = 32'h0;

    always @(posedge clk) begin
        if (reset) begin
            m_pc <= 32'h0000_3000; m_pend <= 1'b0; m_hold <= 32'h0;
        end else if (exc_req || eret_req) begin
            m_pc   <= exc_req ? 32'h0000_4180 : epc;
            m_pend <= 1'b0;
        end else if (stall) begin
            if (br_valid) begin
                m_hold <= br_target; m_pend <= 1'b1;
            end
        end else begin
            m_pc   <= br_valid ? br_target : (m_pend ? m_hold : m_pc + 32'd4);
            m_pend <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model pc_f", pc_f, m_pc);
        chk("model pc_seq", pc_seq, m_pc + 32'd4);
        chk("model fetch_adel", {31'b0, fetch_adel},
            {31'b0, (m_pc[1:0] != 2'b00) || (m_pc < 32'h3000) || (m_pc > 32'h6FFC)});
        chk("model redir_pending", {31'b0, redir_pending}, {31'b0, m_pend});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        chk("sim start pc_f", pc_f, 32'h0000_3000);
        cyc(); cyc();
        reset = 1'b0;
        chk("reset pc_f", pc_f, 32'h0000_3000);
        chk("reset adel", {31'b0, fetch_adel}, 32'd0);
        chk("wrap reset pc_f", pc_f2, 32'hFFFF_FFFC);
        chk("wrap reset adel", {31'b0, fetch_adel2}, 32'd1);
        chk("wrap pc_seq", pc_seq2, 32'h0000_0000);
        cyc();
        chk("run1", pc_f, 32'h0000_3004);
        chk("wrap pc_f", pc_f2, 32'h0000_0000);
        cyc(); chk("run2", pc_f, 32'h0000_3008);
        cyc(); chk("run3", pc_f, 32'h0000_300C);
        chk("run3 adel", {31'b0, fetch_adel}, 32'd0);

        // Back to 0x3008, then stall with branch in first stall cycle.
        reset = 1'b1; cyc(); reset = 1'b0;
        cyc(); cyc();
        chk("pre-stall", pc_f, 32'h0000_3008);
        stall = 1'b1; br_valid = 1'b1; br_target = 32'h0000_3100;
        cyc();
        br_valid = 1'b0;
        chk("stall hold", pc_f, 32'h0000_3008);
        chk("stall pend", {31'b0, redir_pending}, 32'd1);
        cyc();
        chk("stall hold2", pc_f, 32'h0000_3008);
        stall = 1'b0;
        cyc();
        chk("release pc", pc_f, 32'h0000_3100);
        chk("release pend", {31'b0, redir_pending}, 32'd0);
        cyc();
        chk("after release", pc_f, 32'h0000_3104);

        // Overwrite of held target.
        stall = 1'b1; br_valid = 1'b1; br_target = 32'h0000_3100;
        cyc();
        br_target = 32'h0000_3200;
        cyc();
        stall = 1'b0; br_valid = 1'b0;
        cyc();
        chk("overwrite", pc_f, 32'h0000_3200);

        // Everything at once: exception wins and clears pending.
        exc_req = 1'b1; eret_req = 1'b1; br_valid = 1'b1; stall = 1'b1;
        br_target = 32'h0000_3300; epc = 32'h0000_300C;
        cyc();
        chk("exc pc", pc_f, 32'h0000_4180);
        chk("exc pend", {31'b0, redir_pending}, 32'd0);
        exc_req = 1'b0; br_valid = 1'b0; stall = 1'b0;
        cyc();
        chk("eret pc", pc_f, 32'h0000_300C);
        eret_req = 1'b0;

        // Eret under stall still redirects.
        stall = 1'b1; eret_req = 1'b1; epc = 32'h0000_3400;
        cyc();
        chk("eret stall", pc_f, 32'h0000_3400);
        stall = 1'b0; eret_req = 1'b0;

        // Address error cases.
        br_valid = 1'b1; br_target = 32'h0000_3002;
        cyc();
        chk("misaligned pc", pc_f, 32'h0000_3002);
        chk("misaligned adel", {31'b0, fetch_adel}, 32'd1);
        br_target = 32'h0000_7000;
        cyc();
        chk("range adel", {31'b0, fetch_adel}, 32'd1);
        br_target = 32'h0000_6FFC;
        cyc();
        chk("hi edge adel", {31'b0, fetch_adel}, 32'd0);
        br_valid = 1'b0;
        cyc();
        chk("adel seq", pc_f, 32'h0000_7000);

        // Reset during stall with pending redirect.
        stall = 1'b1; br_valid = 1'b1; br_target = 32'h0000_3100;
        cyc();
        br_valid = 1'b0;
        chk("pend before reset", {31'b0, redir_pending}, 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("reset mid-stall pc", pc_f, 32'h0000_3000);
        chk("reset mid-stall pend", {31'b0, redir_pending}, 32'd0);
        cyc();
        stall = 1'b0;
        cyc();
        chk("post reset release", pc_f, 32'h0000_3004);
        cyc(); cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
